prod_acc_round: RTL and testbench

//   Downstream consumer of the pipelined signed multiplier. Accumulates a stream of

---
 rtl/prod_acc_round.sv | 136 +++++++++++++
 tb/tb_prod_acc_round.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prod_acc_round.sv
// Dot-product accumulator: sums signed product beats per vector, then rounds
// (half toward +inf), shifts, saturates to OW bits and emits on valid/ready.
module prod_acc_round #(
    parameter  int MW     = 46,
    parameter  int MAXLEN = 256,
    parameter  int SHIFT  = 20,
    parameter  int OW     = 24,
    localparam int ACW    = MW + $clog2(MAXLEN),
    localparam int CW     = $clog2(MAXLEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_sat,
    output logic          out_trunc,
    output logic [CW-1:0] out_len
);

    typedef enum logic {S_ACC = 1'b0, S_FIN = 1'b1} state_t;

    localparam logic signed [ACW:0] C_MAX = {{(ACW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACW:0] C_MIN = {{(ACW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACW-1:0]         r_acc;
    logic [CW-1:0]          r_cnt;
    logic [ACW-1:0]         r_fin;
    logic [CW-1:0]          r_len;
    logic                   r_trunc;

    logic                   w_accept;
    logic                   w_end;
    logic [CW-1:0]          w_cnt_inc;
    logic [ACW-1:0]         w_sum;
    logic signed [ACW:0]    w_round;
    logic                   w_sat_hi;
    logic                   w_sat_lo;
    logic [OW-1:0]          w_out_data;

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_end     = in_last || (w_cnt_inc == CW'(MAXLEN));
    assign w_sum     = r_acc + {{(ACW - MW){in_data[MW-1]}}, in_data};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACC:   if (w_accept && w_end) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_ACC;
            default: w_state_next = S_ACC;
        endcase
    end

    // FSM outputs: a held, unaccepted result blocks further beats
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_ACC:   in_ready = !(out_valid && !out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_fin   <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else if (w_accept) begin
            if (w_end) begin
                r_fin   <= w_sum;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_len   <= w_cnt_inc;
                r_trunc <= !in_last;
            end else begin
                r_acc   <= w_sum;
                r_cnt   <= w_cnt_inc;
            end
        end
    end

    // One extra bit keeps the rounding bias from wrapping at the accumulator's extremes
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACW:0] C_BIAS = (ACW + 1)'(1) << (SHIFT - 1);
            logic signed [ACW:0] w_biased;
            assign w_biased = $signed({r_fin[ACW-1], r_fin}) + C_BIAS;
            assign w_round  = w_biased >>> SHIFT;
        end else begin : g_noround
            assign w_round = $signed({r_fin[ACW-1], r_fin});
        end
    endgenerate

    assign w_sat_hi   = w_round > C_MAX;
    assign w_sat_lo   = w_round < C_MIN;
    assign w_out_data = w_sat_hi ? C_MAX[OW-1:0] :
                        w_sat_lo ? C_MIN[OW-1:0] : w_round[OW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
            out_len   <= '0;
        end else if (r_state == S_FIN) begin
            out_valid <= 1'b1;
            out_data  <= w_out_data;
            out_sat   <= w_sat_hi || w_sat_lo;
            out_trunc <= r_trunc;
            out_len   <= r_len;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prod_acc_round.sv
// Directed bench for prod_acc_round: expected results are queued as vectors are
// driven and compared against each output handshake.
module tb_prod_acc_round;

    localparam int MW     = 16;
    localparam int MAXLEN = 4;
    localparam int SHIFT  = 4;
    localparam int OW     = 8;
    localparam int CW     = $clog2(MAXLEN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic          out_trunc;
    logic [CW-1:0] out_len;

    typedef struct {
        int data;
        int sat;
        int trunc;
        int len;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    prod_acc_round #(
        .MW    (MW),
        .MAXLEN(MAXLEN),
        .SHIFT (SHIFT),
        .OW    (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_trunc(out_trunc),
        .out_len  (out_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        n_vec++;
        assert (obs === 32'(exp)) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int s, input int t, input int l);
        exp_t e;
        e.data = d; e.sat = s; e.trunc = t; e.len = l;
        sb.push_back(e);
    endtask

    // Drives one beat and holds it until accepted; returns 1 ns after the accepting edge
    task automatic send(input int d, input bit last);
        in_data  = MW'(d);
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Output monitor: one line per completed result handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result data=%0d sat=%0d trunc=%0d len=%0d", $signed(out_data), out_sat, out_trunc, out_len);
                chk("out_data", $signed(out_data), e.data);
                chk("out_sat", 32'(out_sat), e.sat);
                chk("out_trunc", 32'(out_trunc), e.trunc);
                chk("out_len", 32'(out_len), e.len);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_out_len", 32'(out_len), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // 1: three beats, latency of two cycles after the last accept
        push(4, 0, 0, 3);
        send(10, 0);
        send(20, 0);
        send(30, 1);
        @(negedge clk);
        chk("t1_valid_fin", 32'(out_valid), 0);
        chk("t1_ready_fin", 32'(in_ready), 0);
        @(negedge clk);
        chk("t1_valid_t2", 32'(out_valid), 1);
        wait_drain();

        // 2: rounding of negatives
        push(0, 0, 0, 1);
        send(-8, 1);
        push(-1, 0, 0, 1);
        send(-9, 1);
        wait_drain();

        // 3: saturation both ways
        push(127, 1, 0, 1);
        send(5000, 1);
        push(-128, 1, 0, 1);
        send(-5000, 1);
        wait_drain();

        // 4: MAXLEN forces vector end; the fifth beat opens a new vector
        push(4, 0, 1, 4);
        for (int i = 0; i < 4; i++) send(16, 0);
        push(2, 0, 0, 2);
        send(16, 0);
        send(16, 1);
        wait_drain();

        // 5: held result blocks the next vector's final beat
        out_ready = 1'b0;
        push(1, 0, 0, 1);
        send(16, 1);
        repeat (2) @(negedge clk);
        chk("t5_a_valid", 32'(out_valid), 1);
        push(2, 0, 0, 1);
        in_data  = MW'(32);
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_in_ready_blocked", 32'(in_ready), 0);
            chk("t5_a_held", $signed(out_data), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32, 1);
        wait_drain();

        // 6: asynchronous reset discards a partial vector and clears outputs
        send(100, 0);
        send(100, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_data", $signed(out_data), 0);
        chk("t6_out_sat", 32'(out_sat), 0);
        chk("t6_out_trunc", 32'(out_trunc), 0);
        chk("t6_out_len", 32'(out_len), 0);
        #1;
        rst = 1'b0;
        push(1, 0, 0, 1);
        send(16, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
